// File: rtl/rfseq_pkg.sv
// Shared types and constants for the register-file read sequencer.
// Slot numbering follows the use_mask bit order (Rn, Rm, Rs).
package rfseq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } rfseq_state_t;

    localparam logic [1:0] SLOT_RN = 2'd0;
    localparam logic [1:0] SLOT_RM = 2'd1;
    localparam logic [1:0] SLOT_RS = 2'd2;

    localparam logic [3:0] PC_IDX = 4'd15;

    // Maps an operand slot to the register index latched for that slot.
    function automatic logic [3:0] slot_index(
        input logic [1:0] slot,
        input logic [3:0] rn,
        input logic [3:0] rm,
        input logic [3:0] rs
    );
        logic [3:0] idx;
        idx = rn;
        case (slot)
            SLOT_RN: idx = rn;
            SLOT_RM: idx = rm;
            SLOT_RS: idx = rs;
            default: idx = rn;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/rfseq_next_slot.sv
// Finds the next operand slot that still needs a read.
// With from_start set the search includes slot 0, giving the first slot of a new request.
module rfseq_next_slot
    import rfseq_pkg::*;
(
    input  logic [2:0] mask,
    input  logic [1:0] slot,
    input  logic       from_start,
    output logic [1:0] next_slot,
    output logic       none
);

    logic [2:0] candidate;

    // A slot is a candidate when it is requested and lies strictly above the current one.
    always_comb begin
        candidate    = 3'b000;
        candidate[0] = mask[0] & from_start;
        candidate[1] = mask[1] & (from_start | (slot == SLOT_RN));
        candidate[2] = mask[2] & (from_start | (slot == SLOT_RN) | (slot == SLOT_RM));
    end

    always_comb begin
        next_slot = SLOT_RN;
        none      = 1'b0;
        if (candidate[0]) begin
            next_slot = SLOT_RN;
        end else if (candidate[1]) begin
            next_slot = SLOT_RM;
        end else if (candidate[2]) begin
            next_slot = SLOT_RS;
        end else begin
            none = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_read_sequencer.sv
// Serialises up to three operand reads (Rn, Rm, Rs) through one shared 16:1 read mux
// and hands the collected operands to execute over a valid/ready handshake.
module regfile_read_sequencer
    import rfseq_pkg::*;
#(
    parameter int BUS = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [3:0]     rn_idx,
    input  logic [3:0]     rm_idx,
    input  logic [3:0]     rs_idx,
    input  logic [2:0]     use_mask,
    input  logic [BUS-1:0] pc_val,
    output logic [3:0]     mux_sel,
    input  logic [BUS-1:0] mux_data,
    output logic [BUS-1:0] op_a,
    output logic [BUS-1:0] op_b,
    output logic [BUS-1:0] op_c,
    output logic           out_valid,
    input  logic           out_ready
);

    rfseq_state_t   state_q;
    logic [1:0]     slot_q;
    logic [2:0]     mask_q;
    logic [3:0]     rn_q;
    logic [3:0]     rm_q;
    logic [3:0]     rs_q;

    logic [1:0]     first_slot;
    logic           first_none;
    logic [1:0]     next_slot;
    logic           next_none;
    logic [3:0]     cur_idx;
    logic [BUS-1:0] capture;

    rfseq_next_slot u_first_slot (
        .mask       (use_mask),
        .slot       (SLOT_RN),
        .from_start (1'b1),
        .next_slot  (first_slot),
        .none       (first_none)
    );

    rfseq_next_slot u_next_slot (
        .mask       (mask_q),
        .slot       (slot_q),
        .from_start (1'b0),
        .next_slot  (next_slot),
        .none       (next_none)
    );

    // R15 never goes through the mux: the PC+8 value supplied by fetch replaces it.
    always_comb begin
        cur_idx = slot_index(slot_q, rn_q, rm_q, rs_q);
        capture = (cur_idx == PC_IDX) ? pc_val : mux_data;
    end

    // Handshake and select are decoded from registered state only, and forced quiet in reset.
    always_comb begin
        req_ready = rst_n && (state_q == IDLE);
        out_valid = rst_n && (state_q == DONE);
        mux_sel   = (rst_n && (state_q == READ)) ? cur_idx : 4'd0;
    end

    // Flush outranks every handshake; operand registers only change on accept or capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            slot_q  <= SLOT_RN;
            mask_q  <= 3'b000;
            rn_q    <= 4'd0;
            rm_q    <= 4'd0;
            rs_q    <= 4'd0;
            op_a    <= '0;
            op_b    <= '0;
            op_c    <= '0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        rn_q   <= rn_idx;
                        rm_q   <= rm_idx;
                        rs_q   <= rs_idx;
                        mask_q <= use_mask;
                        op_a   <= '0;
                        op_b   <= '0;
                        op_c   <= '0;
                        if (first_none) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= READ;
                            slot_q  <= first_slot;
                        end
                    end
                end
                READ: begin
                    case (slot_q)
                        SLOT_RN: op_a <= capture;
                        SLOT_RM: op_b <= capture;
                        SLOT_RS: op_c <= capture;
                        default: op_a <= capture;
                    endcase
                    if (next_none) begin
                        state_q <= DONE;
                    end else begin
                        slot_q <= next_slot;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
